mem_arbiter: RTL and testbench

- Shares the single-port program/data RAM of customComputer between two requesters.
  - Port 0: the CPU fetch/execute path.
  - Port 1: the program loader/debug path.
- Runs one transaction at a time through a fixed-latency access sequence.
- Resolves simultaneous requests round-robin, so neither requester starves.
- Sits between the CPU/loader and the RAM instance inside customComputer, clocked by CLOCK_50.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port program/data RAM between the CPU
// (port 0) and the loader/debug path (port 1). One transaction at a time,
// fixed access sequence IDLE -> ACCESS -> WAIT x MEM_LAT -> DONE, with
// round-robin resolution of simultaneous requests.
module mem_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int MEM_LAT = 1
) (
   input  logic              CLOCK_50,
   input  logic              reset,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic [1:0]        grant,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   // MEM_LAT is limited to 1..7, so three bits hold the whole wait count
   localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

   state_t            state_reg;
   logic              last_served_reg;   // index of the port that completed last
   logic              winner_reg;        // index of the port owning the transaction
   logic              we_reg;            // latched direction of the transaction
   logic [2:0]        wait_cnt_reg;

   logic              pick_next;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              rd_capture;

   // Arbitration: a lone request wins outright, a tie goes to the port
   // that was not served last so neither side can starve the other.
   always_comb begin
      pick_next = m1_req;
      if (m0_req && m1_req) begin
         pick_next = ~last_served_reg;
      end
      sel_we    = pick_next ? m1_we    : m0_we;
      sel_addr  = pick_next ? m1_addr  : m0_addr;
      sel_wdata = pick_next ? m1_wdata : m0_wdata;
   end

   // Read data is sampled on the last WAIT edge, when the RAM pipeline
   // presents the word addressed during ACCESS.
   assign rd_capture = (state_reg == WAIT) && (wait_cnt_reg == 3'd1) && !we_reg;

   // Access sequencer; every strobe is registered so it lines up with the
   // state it belongs to (mem_en is set on the edge that enters ACCESS).
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_reg       <= IDLE;
         last_served_reg <= 1'b1;
         winner_reg      <= 1'b0;
         we_reg          <= 1'b0;
         wait_cnt_reg    <= 3'd0;
         grant           <= 2'b00;
         busy            <= 1'b0;
         mem_en          <= 1'b0;
         mem_we          <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         m0_ack          <= 1'b0;
         m1_ack          <= 1'b0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (m0_req || m1_req) begin
                  winner_reg <= pick_next;
                  we_reg     <= sel_we;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_en     <= 1'b1;
                  mem_we     <= sel_we;
                  grant      <= pick_next ? 2'b10 : 2'b01;
                  busy       <= 1'b1;
                  state_reg  <= ACCESS;
               end
            end
            ACCESS: begin
               mem_en       <= 1'b0;
               mem_we       <= 1'b0;
               wait_cnt_reg <= LAT_LOAD;
               state_reg    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt_reg == 3'd1) begin
                  m0_ack    <= ~winner_reg;
                  m1_ack    <= winner_reg;
                  state_reg <= DONE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 3'd1;
               end
            end
            DONE: begin
               last_served_reg <= winner_reg;
               grant           <= 2'b00;
               busy            <= 1'b0;
               state_reg       <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Per-port read data holding registers; only the owning port's copy
   // changes, and only on a read.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rdata_reg;

      // Capture the RAM word for this port when its read completes.
      always_ff @(posedge CLOCK_50) begin
         if (reset) begin
            rdata_reg <= '0;
         end else if (rd_capture && (winner_reg == 1'(gi))) begin
            rdata_reg <= mem_rdata;
         end
      end
   end

   assign m0_rdata = g_port[0].rdata_reg;
   assign m1_rdata = g_port[1].rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RAM latency 1 and 3), each with its
// own RAM model, a transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT     = (gi == 0) ? 1 : 3;
      localparam int EXP_LAT = (gi == 0) ? 3 : 5;   // req cycle to ack cycle

      logic       rst;
      logic       req   [2];
      logic       we    [2];
      logic [7:0] addr  [2];
      logic [7:0] wdata [2];
      logic       ack   [2];
      logic [7:0] rdata [2];
      logic       mem_en, mem_we;
      logic [7:0] mem_addr, mem_wdata, mem_rdata;
      logic [1:0] grant;
      logic       busy;
      bit         done = 1'b0;
      int         cyc  = 0;

      mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) dut (
         .CLOCK_50 (clk),
         .reset    (rst),
         .m0_req   (req[0]),
         .m0_we    (we[0]),
         .m0_addr  (addr[0]),
         .m0_wdata (wdata[0]),
         .m0_ack   (ack[0]),
         .m0_rdata (rdata[0]),
         .m1_req   (req[1]),
         .m1_we    (we[1]),
         .m1_addr  (addr[1]),
         .m1_wdata (wdata[1]),
         .m1_ack   (ack[1]),
         .m1_rdata (rdata[1]),
         .mem_en   (mem_en),
         .mem_we   (mem_we),
         .mem_addr (mem_addr),
         .mem_wdata(mem_wdata),
         .mem_rdata(mem_rdata),
         .grant    (grant),
         .busy     (busy)
      );

      always @(posedge clk) cyc <= cyc + 1;

      // RAM model: write on mem_en&&mem_we, read word appears LAT cycles
      // after the cycle in which its address was presented.
      logic [7:0] ram  [256];
      logic [7:0] pipe [LAT];
      bit         ram_ready = 1'b0;
      logic       poke_en;
      logic [7:0] poke_addr, poke_data;

      always @(posedge clk) begin
         if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 11);
            ram_ready <= 1'b1;
         end else if (poke_en) begin
            ram[poke_addr] <= poke_data;
         end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
         end
         pipe[0] <= ram[mem_addr];
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign mem_rdata = pipe[LAT-1];

      // Reference model: a transaction starting in idle cycle s owns the
      // bus for cycles s+1 .. s+2+LAT; strobe in s+1, ack in s+2+LAT.
      logic [7:0] ref_mem [256];
      int         s = -1;
      bit         mw, mwe;
      logic [7:0] maddr, mwdata;
      bit         last = 1'b1;
      bit         began = 1'b0;
      bit         model_init = 1'b0;
      logic [7:0] exp_addr = 8'h00, exp_wdata = 8'h00;
      logic [7:0] exp_rd [2];

      always @(negedge clk) begin
         int         k;
         bit         was_idle, w;
         logic [1:0] eg;
         bit         een, ewe;
         bit         eack [2];
         if (!model_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
            exp_rd[0] = 8'h00;
            exp_rd[1] = 8'h00;
            model_init = 1'b1;
         end
         if (poke_en === 1'b1) ref_mem[poke_addr] = poke_data;
         was_idle = (s < 0);
         k = 0;
         eg = 2'b00; een = 1'b0; ewe = 1'b0;
         eack[0] = 1'b0; eack[1] = 1'b0;
         if (!was_idle) begin
            k  = cyc - s;
            eg = mw ? 2'b10 : 2'b01;
            if (k == 1) begin
               een = 1'b1;
               ewe = mwe;
               if (mwe) ref_mem[maddr] = mwdata;
            end
            if (k == 2 + LAT) begin
               eack[mw] = 1'b1;
               if (!mwe) exp_rd[mw] = ref_mem[maddr];
            end
         end
         if (began) begin
            chk($sformatf("L%0d c%0d grant", LAT, cyc), int'(grant), int'(eg));
            chk($sformatf("L%0d c%0d busy", LAT, cyc), int'(busy), int'(eg != 2'b00));
            chk($sformatf("L%0d c%0d mem_en", LAT, cyc), int'(mem_en), int'(een));
            chk($sformatf("L%0d c%0d mem_we", LAT, cyc), int'(mem_we), int'(ewe));
            chk($sformatf("L%0d c%0d m0_ack", LAT, cyc), int'(ack[0]), int'(eack[0]));
            chk($sformatf("L%0d c%0d m1_ack", LAT, cyc), int'(ack[1]), int'(eack[1]));
            chk($sformatf("L%0d c%0d m0_rdata", LAT, cyc), int'(rdata[0]), int'(exp_rd[0]));
            chk($sformatf("L%0d c%0d m1_rdata", LAT, cyc), int'(rdata[1]), int'(exp_rd[1]));
            chk($sformatf("L%0d c%0d mem_addr", LAT, cyc), int'(mem_addr), int'(exp_addr));
            chk($sformatf("L%0d c%0d mem_wdata", LAT, cyc), int'(mem_wdata), int'(exp_wdata));
         end
         if (!was_idle && k == 2 + LAT) begin
            last = mw;
            s = -1;
         end
         if (rst) begin
            s = -1; last = 1'b1; began = 1'b1;
            exp_addr = 8'h00; exp_wdata = 8'h00;
            exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
         end else if (was_idle && began && (req[0] || req[1])) begin
            w = (req[0] && req[1]) ? !last : req[1];
            s = cyc; mw = w; mwe = we[w]; maddr = addr[w]; mwdata = wdata[w];
            exp_addr = maddr; exp_wdata = mwdata;
         end
      end

      int order_q [$];
      int exp_order [6] = '{0, 1, 0, 1, 0, 1};

      task automatic poke(input logic [7:0] a, input logic [7:0] d);
         @(posedge clk); #1;
         poke_en = 1'b1; poke_addr = a; poke_data = d;
         @(posedge clk); #1;
         poke_en = 1'b0;
      endtask

      task automatic txn(input int p, input bit w_en, input logic [7:0] a,
                         input logic [7:0] d, output int lat,
                         output logic [7:0] rd, output int en_pulses);
         int n;
         @(posedge clk); #1;
         req[p] = 1'b1; we[p] = w_en; addr[p] = a; wdata[p] = d;
         n = cyc; lat = -1; rd = 8'h00; en_pulses = 0;
         for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (mem_en) en_pulses++;
            if (ack[p]) begin
               lat = cyc - n;
               rd  = rdata[p];
               break;
            end
         end
         req[p] = 1'b0;
      endtask

      task automatic run_both(input int n, output int both_cnt);
         order_q.delete();
         both_cnt = 0;
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            req[p] = 1'b1; we[p] = 1'b0; addr[p] = 8'(p + 4);
         end
         for (int t = 0; t < n * (LAT + 4) + 20 && order_q.size() < n; t++) begin
            @(posedge clk); #1;
            if (ack[0] && ack[1]) both_cnt++;
            if (ack[0]) order_q.push_back(0);
            if (ack[1]) order_q.push_back(1);
         end
         req[0] = 1'b0; req[1] = 1'b0;
      endtask

      initial begin
         int         lat, en_cnt, both, cnt;
         logic [7:0] rd;
         bit         outst [2];
         rst = 1'b1; poke_en = 1'b0; poke_addr = 8'h00; poke_data = 8'h00;
         for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = 8'h00; wdata[p] = 8'h00;
            outst[p] = 1'b0;
         end
         repeat (3) @(posedge clk);
         #1 rst = 1'b0;
         chk($sformatf("L%0d reset grant", LAT), int'(grant), 0);
         chk($sformatf("L%0d reset busy", LAT), int'(busy), 0);
         chk($sformatf("L%0d reset m0_rdata", LAT), int'(rdata[0]), 0);

         // single read
         poke(8'h10, 8'hA5);
         txn(0, 1'b0, 8'h10, 8'h00, lat, rd, en_cnt);
         chk($sformatf("L%0d read latency", LAT), lat, EXP_LAT);
         chk($sformatf("L%0d read data", LAT), int'(rd), 'hA5);
         chk($sformatf("L%0d read mem_en pulses", LAT), en_cnt, 1);
         @(posedge clk); #1;
         chk($sformatf("L%0d busy after read", LAT), int'(busy), 0);

         // write then read back on port 1
         txn(1, 1'b1, 8'h20, 8'h3C, lat, rd, en_cnt);
         chk($sformatf("L%0d write latency", LAT), lat, EXP_LAT);
         chk($sformatf("L%0d write mem_en pulses", LAT), en_cnt, 1);
         chk($sformatf("L%0d write keeps m1_rdata", LAT), int'(rdata[1]), 0);
         txn(1, 1'b0, 8'h20, 8'h00, lat, rd, en_cnt);
         chk($sformatf("L%0d readback data", LAT), int'(rd), 'h3C);

         // tie and fairness
         run_both(6, both);
         chk($sformatf("L%0d tie ack count", LAT), order_q.size(), 6);
         chk($sformatf("L%0d tie double acks", LAT), both, 0);
         for (int i = 0; i < order_q.size() && i < 6; i++)
            chk($sformatf("L%0d tie order %0d", LAT, i), order_q[i], exp_order[i]);

         // reset during WAIT of a port 0 read
         @(posedge clk); #1;
         req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h10;
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("L%0d busy in WAIT", LAT), int'(busy), 1);
         rst = 1'b1; req[0] = 1'b0;
         @(posedge clk); #1;
         rst = 1'b0;
         chk($sformatf("L%0d abort grant", LAT), int'(grant), 0);
         chk($sformatf("L%0d abort busy", LAT), int'(busy), 0);
         chk($sformatf("L%0d abort mem_en", LAT), int'(mem_en), 0);
         chk($sformatf("L%0d abort m0_ack", LAT), int'(ack[0]), 0);
         chk($sformatf("L%0d abort m0_rdata", LAT), int'(rdata[0]), 0);
         run_both(2, both);
         chk($sformatf("L%0d post-reset acks", LAT), order_q.size(), 2);
         if (order_q.size() > 0)
            chk($sformatf("L%0d post-reset first", LAT), order_q[0], 0);

         // write whose req drops during WAIT
         @(posedge clk); #1;
         req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h33; wdata[1] = 8'h5A;
         repeat (2) @(posedge clk);
         #1 req[1] = 1'b0;
         cnt = 0;
         for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            if (ack[1]) cnt++;
         end
         chk($sformatf("L%0d dropped req acks", LAT), cnt, 1);
         chk($sformatf("L%0d dropped req RAM", LAT), int'(ram[8'h33]), 'h5A);

         // randomized traffic with occasional mid-transaction drops
         for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
               if (outst[p] && ack[p]) outst[p] = 1'b0;
               if (outst[p]) begin
                  if (req[p] && grant[p] && $urandom_range(0, 3) == 0) req[p] = 1'b0;
               end else if ($urandom_range(0, 2) == 0) begin
                  req[p]   = 1'b1;
                  we[p]    = 1'($urandom_range(0, 1));
                  addr[p]  = 8'($urandom_range(0, 15));
                  wdata[p] = 8'($urandom);
                  outst[p] = 1'b1;
               end else begin
                  req[p] = 1'b0;
               end
            end
         end
         // let outstanding transactions finish
         for (int t = 0; t < 60 && (outst[0] || outst[1]); t++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
               if (outst[p] && ack[p]) outst[p] = 1'b0;
               if (!outst[p]) req[p] = 1'b0;
            end
         end
         req[0] = 1'b0; req[1] = 1'b0;
         repeat (LAT + 4) @(posedge clk);
         done = 1'b1;
      end
   end

   initial begin
      for (int t = 0; t < 20000; t++) begin
         @(posedge clk);
         if (g_inst[0].done && g_inst[1].done) break;
      end
      if (!(g_inst[0].done && g_inst[1].done)) begin
         vectors++;
         miscompares++;
         $display("FAIL run_timeout: done flags %0d%0d, expected 11",
                  g_inst[0].done, g_inst[1].done);
      end
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
